// File: rtl/ex_stage_skid_reg.sv
// Decode-to-execute pipeline register with a valid/ready handshake, a two-entry
// skid buffer (main + skid) and synchronous flush. in_ready is fully registered.
module ex_stage_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 3,
  parameter int REG_AW  = 4,
  parameter int ALU_W   = 3,
  parameter int CTRL_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] ops_i,
  input  logic [REG_AW-1:0]         dest_reg_i,
  input  logic [ALU_W-1:0]          alu_ins_i,
  input  logic [CTRL_W-1:0]         ctrl_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] ops_o,
  output logic [REG_AW-1:0]         dest_reg_o,
  output logic [ALU_W-1:0]          alu_ins_o,
  output logic [CTRL_W-1:0]         ctrl_o
);

  localparam int OPS_W = NUM_OPS * DATA_W;
  localparam int PAY_W = OPS_W + REG_AW + ALU_W + CTRL_W;

  logic             r_m_vld;
  logic             r_s_vld;
  logic             r_in_ready;
  logic [PAY_W-1:0] r_m_pay;
  logic [PAY_W-1:0] r_s_pay;

  logic [PAY_W-1:0] w_in_pay;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_m_free;

  assign w_in_pay   = {ops_i, dest_reg_i, alu_ins_i, ctrl_i};
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_m_vld & out_ready;
  assign w_m_free   = ~r_m_vld | w_out_fire;

  // ---- main / skid storage update ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_vld    <= 1'b0;
      r_s_vld    <= 1'b0;
      r_in_ready <= 1'b1;
      r_m_pay    <= '0;
      r_s_pay    <= '0;
    end else if (flush) begin
      r_m_vld    <= 1'b0;
      r_s_vld    <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_m_free) begin
      if (r_s_vld) begin
        // Skid entry is older than anything arriving now, so it moves up first.
        r_m_pay    <= r_s_pay;
        r_m_vld    <= 1'b1;
        r_s_vld    <= w_in_fire;
        r_in_ready <= ~w_in_fire;
        if (w_in_fire) begin
          r_s_pay <= w_in_pay;
        end
      end else begin
        r_m_vld    <= w_in_fire;
        r_in_ready <= 1'b1;
        if (w_in_fire) begin
          r_m_pay <= w_in_pay;
        end
      end
    end else if (w_in_fire) begin
      r_s_pay    <= w_in_pay;
      r_s_vld    <= 1'b1;
      r_in_ready <= 1'b0;
    end
  end

  // ---- presented entry ----
  assign in_ready   = r_in_ready;
  assign out_valid  = r_m_vld;
  assign ops_o      = r_m_pay[PAY_W-1 -: OPS_W];
  assign dest_reg_o = r_m_pay[ALU_W+CTRL_W +: REG_AW];
  assign alu_ins_o  = r_m_pay[CTRL_W +: ALU_W];
  // A bubble must never write state or redirect the PC.
  assign ctrl_o     = r_m_vld ? r_m_pay[CTRL_W-1:0] : '0;

endmodule

// File: tb/tb_ex_stage_skid_reg.sv
// Bench for ex_stage_skid_reg: scenario tasks with inline checks plus a
// queue scoreboard that checks every entry leaving the stage.
module tb_ex_stage_skid_reg;

  localparam int DATA_W  = 32;
  localparam int NUM_OPS = 3;
  localparam int REG_AW  = 4;
  localparam int ALU_W   = 3;
  localparam int CTRL_W  = 6;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_OPS*DATA_W-1:0] ops_i;
  logic [REG_AW-1:0]         dest_reg_i;
  logic [ALU_W-1:0]          alu_ins_i;
  logic [CTRL_W-1:0]         ctrl_i;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_OPS*DATA_W-1:0] ops_o;
  logic [REG_AW-1:0]         dest_reg_o;
  logic [ALU_W-1:0]          alu_ins_o;
  logic [CTRL_W-1:0]         ctrl_o;

  typedef struct packed {
    logic [NUM_OPS*DATA_W-1:0] ops;
    logic [REG_AW-1:0]         dest;
    logic [ALU_W-1:0]          alu;
    logic [CTRL_W-1:0]         ctrl;
  } ent_t;

  ent_t sb[$];
  int   n_vec;
  int   n_err;

  ex_stage_skid_reg #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .REG_AW(REG_AW),
    .ALU_W(ALU_W), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ops_i(ops_i), .dest_reg_i(dest_reg_i), .alu_ins_i(alu_ins_i), .ctrl_i(ctrl_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .ops_o(ops_o), .dest_reg_o(dest_reg_o), .alu_ins_o(alu_ins_o), .ctrl_o(ctrl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs are stable at negedge, so fires seen here are the
  // fires of the following posedge.
  always @(negedge clk) begin
    ent_t got;
    ent_t exp;
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        got = {ops_o, dest_reg_o, alu_ins_o, ctrl_o};
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got %h required <no entry>", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL sb_entry: got %h required %h", got, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({ops_i, dest_reg_i, alu_ins_i, ctrl_i});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] lane0);
    in_valid   = v;
    ops_i      = {DATA_W'($urandom), DATA_W'($urandom), lane0};
    dest_reg_i = REG_AW'($urandom);
    alu_ins_i  = ALU_W'($urandom);
    ctrl_i     = CTRL_W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(0, 1), $urandom);
      out_ready = $urandom_range(0, 1);
      step();
      n_vec++;
      if ({out_valid, in_ready, ops_o, dest_reg_o, alu_ins_o, ctrl_o} !==
          {1'b0, 1'b1, {(NUM_OPS*DATA_W+REG_AW+ALU_W+CTRL_W){1'b0}}}) begin
        n_err++;
        $display("FAIL reset_hold: out_valid=%b in_ready=%b ops=%h dest=%h alu=%h ctrl=%h required 0/1/all-zero",
                 out_valid, in_ready, ops_o, dest_reg_o, alu_ins_o, ctrl_o);
      end
    end
    drive(1'b0, '0);
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if ({out_valid, ops_o, ctrl_o} !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: out_valid=%b ops=%h ctrl=%h in_ready=%b required 0/0/0/1",
               out_valid, ops_o, ctrl_o, in_ready);
    end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i]);
      step();
      n_vec++;
      if (out_valid !== 1'b1 || ops_o[DATA_W-1:0] !== vals[i] || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_%0d: out_valid=%b lane0=%h in_ready=%b required 1/%h/1",
                 i, out_valid, ops_o[DATA_W-1:0], in_ready, vals[i]);
      end
    end
    drive(1'b0, '0);
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    drive(1'b1, 32'hA);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'hB);
    step();
    n_vec++;
    if (out_valid !== 1'b1 || ops_o[DATA_W-1:0] !== 32'hA || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_skid: out_valid=%b lane0=%h in_ready=%b required 1/a/0",
               out_valid, ops_o[DATA_W-1:0], in_ready);
    end
    drive(1'b1, 32'hC);
    step();
    n_vec++;
    if (ops_o[DATA_W-1:0] !== 32'hA || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_block: lane0=%h in_ready=%b required a/0",
               ops_o[DATA_W-1:0], in_ready);
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || ops_o[DATA_W-1:0] !== 32'hB || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release_b: out_valid=%b lane0=%h in_ready=%b required 1/b/1",
               out_valid, ops_o[DATA_W-1:0], in_ready);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b1 || ops_o[DATA_W-1:0] !== 32'hC) begin
      n_err++;
      $display("FAIL stall_release_c: out_valid=%b lane0=%h required 1/c",
               out_valid, ops_o[DATA_W-1:0]);
    end
    drive(1'b0, '0);
    step();
  endtask

  task automatic test_bubble();
    logic [CTRL_W-1:0] c;
    out_ready = 1'b1;
    drive(1'b1, 32'h44);
    c = ctrl_i;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || ctrl_o !== c) begin
      n_err++;
      $display("FAIL bubble_pre: out_valid=%b ctrl=%h required 1/%h", out_valid, ctrl_o, c);
    end
    drive(1'b0, 32'h55);
    ctrl_i = 6'h3F;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || ctrl_o !== 6'h00) begin
      n_err++;
      $display("FAIL bubble_mask: out_valid=%b ctrl=%h required 0/00", out_valid, ctrl_o);
    end
    drive(1'b1, 32'h66);
    step();
    n_vec++;
    if (out_valid !== 1'b1 || ops_o[DATA_W-1:0] !== 32'h66) begin
      n_err++;
      $display("FAIL bubble_post: out_valid=%b lane0=%h required 1/66", out_valid, ops_o[DATA_W-1:0]);
    end
    drive(1'b0, '0);
    step();
  endtask

  task automatic test_flush();
    logic [CTRL_W-1:0] c;
    out_ready = 1'b0;
    drive(1'b1, 32'h70);
    step();
    drive(1'b1, 32'h71);
    step();
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_fill: in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
    end
    drive(1'b1, 32'h72);
    ctrl_i = 6'h04;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    n_vec++;
    if (out_valid !== 1'b0 || ctrl_o !== 6'h00 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_clear: out_valid=%b ctrl=%h in_ready=%b required 0/00/1",
               out_valid, ctrl_o, in_ready);
    end
    drive(1'b1, 32'h73);
    c = ctrl_i;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || ops_o[DATA_W-1:0] !== 32'h73 || ctrl_o !== c) begin
      n_err++;
      $display("FAIL flush_after: out_valid=%b lane0=%h ctrl=%h required 1/73/%h",
               out_valid, ops_o[DATA_W-1:0], ctrl_o, c);
    end
    drive(1'b0, '0);
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h80);
    ctrl_i = 6'h3F;
    step();
    drive(1'b1, 32'h81);
    step();
    drive(1'b0, '0);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || ctrl_o !== 6'h00 || in_ready !== 1'b1 || ops_o !== '0) begin
      n_err++;
      $display("FAIL async_reset: out_valid=%b ctrl=%h in_ready=%b ops=%h required 0/00/1/0",
               out_valid, ctrl_o, in_ready, ops_o);
    end
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || ops_o !== '0) begin
      n_err++;
      $display("FAIL async_reset_release: out_valid=%b ops=%h required 0/0", out_valid, ops_o);
    end
    drive(1'b1, 32'h90);
    step();
    n_vec++;
    if (out_valid !== 1'b1 || ops_o[DATA_W-1:0] !== 32'h90) begin
      n_err++;
      $display("FAIL async_reset_resume: out_valid=%b lane0=%h required 1/90",
               out_valid, ops_o[DATA_W-1:0]);
    end
    drive(1'b0, '0);
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, $urandom);
      out_ready = ($urandom % 3) != 0;
      step();
      n_vec++;
      if (!out_valid && ctrl_o !== '0) begin
        n_err++;
        $display("FAIL random_bubble_ctrl: cycle %0d ctrl=%h required 00", i, ctrl_o);
      end
    end
    drive(1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) begin
      step();
    end
    n_vec++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: pending=%0d out_valid=%b required 0/0", sb.size(), out_valid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
